// File: rtl/mc_pkg.sv
// mc_pkg: state, opcode, ALU-B mux and trap-cause encodings shared by the multicycle RV32I controller.
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_JAL_EX  = 4'd3,
        S_BR_CALC = 4'd4,
        S_ADDR_I  = 4'd5,
        S_ADDR_S  = 4'd6,
        S_R_EX    = 4'd7,
        S_JALR_EX = 4'd8,
        S_BR_EX   = 4'd9,
        S_WB_ALU  = 4'd11,
        S_LD_MEM  = 4'd12,
        S_LD_WB   = 4'd13,
        S_ST_MEM  = 4'd14,
        S_TRAP    = 4'd15
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [1:0] MUX2_FOUR = 2'b00;
    localparam logic [1:0] MUX2_RS2  = 2'b01;
    localparam logic [1:0] MUX2_IMM  = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
endpackage

// File: rtl/mc_store_be.sv
// mc_store_be: store byte enables from funct3/address; an all-zero mask marks a misaligned or unsupported store.
module mc_store_be (
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic [3:0] be,
    output logic       misalign
);
    always_comb begin
        be = 4'b0000;
        case (funct3)
            3'b000:  be = 4'b0001 << addr_lo;
            3'b001:  be = addr_lo[0] ? 4'b0000 : 4'b0011 << {addr_lo[1], 1'b0};
            3'b010:  be = (addr_lo == 2'b00) ? 4'b1111 : 4'b0000;
            default: be = 4'b0000;
        endcase
    end

    assign misalign = (be == 4'b0000);
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle RV32I control FSM with memory-ready timeout and sticky trap.
// Define MC_CTRL_PERF_CNT_EN to add the CYCLE_CNT/INSTRET_CNT performance counters.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int ALU_OP_W    = 11,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_CNT_W    = 4,
    parameter int CNT_W       = 32
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [6:0]          OPCODE,
    input  logic [2:0]          FUNCT3,
    input  logic [1:0]          ADDR_LO,
    input  logic                I_MEM_RDY,
    input  logic                D_MEM_RDY,
    output logic                I_MEM_CSN,
    output logic                D_MEM_CSN,
    output logic                D_MEM_WEN,
    output logic [3:0]          D_MEM_BE,
    output logic                IR_WR,
    output logic                PC_WR,
    output logic                PC_WRITE_COND,
    output logic                ALU_WR,
    output logic                RF_WE,
    output logic                MUX1,
    output logic [1:0]          MUX2,
    output logic                MUX4,
    output logic                REWR_MUX,
    output logic [ALU_OP_W-1:0] ALU_CONTROL,
    output logic [3:0]          STATE,
`ifdef MC_CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0]    CYCLE_CNT,
    output logic [CNT_W-1:0]    INSTRET_CNT,
`endif
    output logic                TRAP,
    output logic [1:0]          TRAP_CAUSE
);
    if ((ALU_OP_W != 11 && ALU_OP_W != 14) || CNT_W < 1 || (MEM_TIMEOUT >> TO_CNT_W) != 0) begin : g_bad_cfg
        $error("mc_ctrl_fsm: illegal ALU_OP_W/CNT_W or TO_CNT_W too narrow for MEM_TIMEOUT");
    end

    state_e              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]          cause_q, cause_d;
    logic [3:0]          st_be;
    logic                st_mis, rdy, timeout;

    mc_store_be u_store_be (
        .funct3  (FUNCT3),
        .addr_lo (ADDR_LO),
        .be      (st_be),
        .misalign(st_mis)
    );

    assign rdy     = (state_q == S_FETCH) ? I_MEM_RDY : D_MEM_RDY;
    assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == TO_CNT_W'(MEM_TIMEOUT)) && !rdy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = I_MEM_RDY ? S_DECODE : timeout ? S_TRAP : S_FETCH;
            S_DECODE:
                case (OPCODE)
                    OP_R:        state_d = S_R_EX;
                    OP_I, OP_LD: state_d = S_ADDR_I;
                    OP_ST:       state_d = S_ADDR_S;
                    OP_JAL:      state_d = S_JAL_EX;
                    OP_JALR:     state_d = S_JALR_EX;
                    OP_BR:       state_d = S_BR_CALC;
                    default:     state_d = S_TRAP;
                endcase
            S_ADDR_I:  state_d = (OPCODE == OP_LD) ? S_LD_MEM : S_WB_ALU;
            S_ADDR_S:  state_d = S_ST_MEM;
            S_R_EX, S_JAL_EX, S_JALR_EX: state_d = S_WB_ALU;
            S_BR_CALC: state_d = S_BR_EX;
            S_BR_EX, S_WB_ALU, S_LD_WB:  state_d = S_FETCH;
            S_LD_MEM:  state_d = D_MEM_RDY ? S_LD_WB : timeout ? S_TRAP : S_LD_MEM;
            S_ST_MEM:  state_d = st_mis ? S_TRAP : D_MEM_RDY ? S_FETCH : timeout ? S_TRAP : S_ST_MEM;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
        cause_d = (state_d == S_TRAP && state_q != S_TRAP)
                ? ((state_q == S_DECODE) ? CAUSE_ILLEGAL
                  : (state_q == S_ST_MEM && st_mis) ? CAUSE_MISALIGN : CAUSE_TIMEOUT)
                : cause_q;
        // Any state change restarts the wait count, so each wait state starts from zero.
        cnt_d = (state_d != state_q) ? '0
              : (!rdy && (state_q == S_FETCH || state_q == S_LD_MEM || state_q == S_ST_MEM)) ? cnt_q + 1'b1
              : cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        IR_WR         = 1'b0;
        PC_WR         = 1'b0;
        PC_WRITE_COND = 1'b0;
        ALU_WR        = 1'b0;
        RF_WE         = 1'b0;
        MUX1          = 1'b0;
        MUX2          = MUX2_FOUR;
        MUX4          = 1'b0;
        REWR_MUX      = 1'b0;
        D_MEM_WEN     = 1'b1;
        D_MEM_BE      = 4'b0000;
        if (RSTn) begin
            case (state_q)
                S_FETCH: begin
                    IR_WR = I_MEM_RDY;
                    PC_WR = I_MEM_RDY;
                end
                S_DECODE: begin
                    ALU_WR = 1'b1;
                    MUX2   = MUX2_IMM;
                end
                S_R_EX: begin
                    ALU_WR = 1'b1;
                    MUX1   = 1'b1;
                    MUX2   = MUX2_RS2;
                end
                S_ADDR_I, S_ADDR_S: begin
                    ALU_WR = 1'b1;
                    MUX1   = 1'b1;
                    MUX2   = MUX2_IMM;
                end
                S_JAL_EX: begin
                    PC_WR  = 1'b1;
                    MUX4   = 1'b1;
                    ALU_WR = 1'b1;
                end
                S_JALR_EX: begin
                    PC_WR  = 1'b1;
                    ALU_WR = 1'b1;
                end
                S_BR_EX: begin
                    MUX1          = 1'b1;
                    MUX2          = MUX2_RS2;
                    PC_WRITE_COND = 1'b1;
                    MUX4          = 1'b1;
                end
                S_WB_ALU: RF_WE = 1'b1;
                S_LD_MEM: D_MEM_BE = 4'b1111;
                S_LD_WB: begin
                    RF_WE    = 1'b1;
                    REWR_MUX = 1'b1;
                end
                S_ST_MEM: begin
                    D_MEM_BE  = st_be;
                    D_MEM_WEN = st_mis;
                end
                default: ;
            endcase
        end
    end

    assign I_MEM_CSN  = ~RSTn;
    assign D_MEM_CSN  = ~RSTn;
    assign STATE      = state_q;
    assign TRAP       = (state_q == S_TRAP);
    assign TRAP_CAUSE = cause_q;

    if (ALU_OP_W == 14) begin : g_alu14
        assign ALU_CONTROL = {FUNCT3, OPCODE, state_q};
    end else begin : g_alu11
        assign ALU_CONTROL = ALU_OP_W'({OPCODE, state_q});
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;

    always_comb begin
        cyc_d = cyc_q + CNT_W'(state_q != S_TRAP);
        ret_d = ret_q + CNT_W'(state_d == S_FETCH && state_q != S_FETCH);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign CYCLE_CNT   = cyc_q;
    assign INSTRET_CNT = ret_q;
`endif
endmodule
